// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the seven-segment scan controller
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam int DEF_SHOW_CYC  = 50000;
    localparam int DEF_BLANK_CYC = 500;

    // All-ones anode pattern for a display of w digits (w <= 32); slice to width at use.
    function automatic logic [31:0] SEG_DARK_AN(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed digit scanner feeding one shared bcd7seg decoder
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG      = 8,
    parameter int SHOW_CYC  = DEF_SHOW_CYC,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [4*NDIG-1:0]   digits,
    input  logic [NDIG-1:0]     dig_en,
    output logic [3:0]          bcd_out,
    output logic [NDIG-1:0]     an_out,
    output logic                frame_done
);

    localparam int MAXC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NDIG);

    localparam logic [31:0]     DARK32     = SEG_DARK_AN(NDIG);
    localparam logic [NDIG-1:0] AN_DARK    = DARK32[NDIG-1:0];
    localparam logic [NDIG-1:0] AN_ONE     = NDIG'(1);
    localparam logic [CW-1:0]   SHOW_LAST  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIG - 1);

    scan_state_t         state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [4*NDIG-1:0]   snap_digits, snap_digits_nxt;
    logic [NDIG-1:0]     snap_en, snap_en_nxt;
    logic [3:0]          bcd_nxt;
    logic [NDIG-1:0]     an_nxt;
    logic                frame_done_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BLANK;
            cnt         <= '0;
            idx         <= IDX_LAST;
            snap_digits <= '0;
            snap_en     <= '0;
            bcd_out     <= 4'h0;
            an_out      <= AN_DARK;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            snap_digits <= snap_digits_nxt;
            snap_en     <= snap_en_nxt;
            bcd_out     <= bcd_nxt;
            an_out      <= an_nxt;
            frame_done  <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt + CW'(1);
        idx_nxt         = idx;
        snap_digits_nxt = snap_digits;
        snap_en_nxt     = snap_en;
        bcd_nxt         = bcd_out;
        an_nxt          = an_out;
        frame_done_nxt  = 1'b0;

        // Disabling parks in a fresh blank slot; idx is kept so the scan resumes at idx+1.
        if (!en) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            an_nxt    = AN_DARK;
        end else if (state == BLANK) begin
            an_nxt = AN_DARK;
            if (cnt == BLANK_LAST) begin
                cnt_nxt   = '0;
                state_nxt = SHOW;
                idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                // Snapshot only at the frame wrap so a frame never mixes old and new codes.
                if (idx_nxt == '0) begin
                    snap_digits_nxt = digits;
                    snap_en_nxt     = dig_en;
                end
                bcd_nxt = snap_digits_nxt[idx_nxt*4 +: 4];
                an_nxt  = snap_en_nxt[idx_nxt] ? ~(AN_ONE << idx_nxt) : AN_DARK;
            end
        end else begin
            if (cnt == SHOW_LAST) begin
                cnt_nxt        = '0;
                state_nxt      = BLANK;
                an_nxt         = AN_DARK;
                frame_done_nxt = (idx == IDX_LAST);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized scoreboard bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int NDIG = 4;
    localparam int SHOW = 3;
    localparam int BLNK = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dig_en;
    logic [3:0]  bcd_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference: each digit slot is a timeline of BLNK dark cycles then SHOW lit cycles.
    int          m_age;
    int          m_idx;
    logic [15:0] m_snap_d;
    logic [3:0]  m_snap_e;
    logic [3:0]  m_bcd;
    logic [3:0]  m_an;
    logic        m_fd;

    int cyc = 0;
    int fd_cyc[$];
    bit record_fd = 1'b0;

    seg_scan_ctrl #(
        .NDIG      (NDIG),
        .SHOW_CYC  (SHOW),
        .BLANK_CYC (BLNK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digits     (digits),
        .dig_en     (dig_en),
        .bcd_out    (bcd_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_age = 0; m_idx = NDIG - 1;
            m_snap_d = '0; m_snap_e = '0;
            m_bcd = 4'h0; m_an = 4'hF; m_fd = 1'b0;
        end else if (!en) begin
            m_age = 0; m_an = 4'hF; m_fd = 1'b0;
        end else begin
            m_fd = 1'b0;
            m_age++;
            if (m_age == BLNK) begin
                m_idx = (m_idx + 1) % NDIG;
                if (m_idx == 0) begin
                    m_snap_d = digits;
                    m_snap_e = dig_en;
                end
                m_bcd = 4'((m_snap_d >> (4 * m_idx)) & 16'hF);
                m_an  = m_snap_e[m_idx] ? 4'(~(1 << m_idx)) : 4'hF;
            end else if (m_age == BLNK + SHOW) begin
                m_age = 0;
                m_an  = 4'hF;
                m_fd  = (m_idx == NDIG - 1);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            cyc++;
            #1;
            check("an_out", 32'(an_out), 32'(m_an));
            check("bcd_out", 32'(bcd_out), 32'(m_bcd));
            check("frame_done", 32'(frame_done), 32'(m_fd));
            if (record_fd && frame_done) fd_cyc.push_back(cyc);
        end
    endtask

    task automatic wait_lit(input int idx);
        int n = 0;
        while (!(m_idx == idx && m_age >= BLNK) && n < 100) begin
            run(1);
            n++;
        end
        if (n >= 100) check("wait_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; digits = 16'h4321; dig_en = 4'b1111;
        run(3);
        check("rst_an", 32'(an_out), 32'hF);
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);

        rst_n = 1'b1;
        cyc = 0;
        record_fd = 1'b1;
        run(1);
        check("first_an", 32'(an_out), 32'hE);
        check("first_bcd", 32'(bcd_out), 32'h1);
        run(39);
        record_fd = 1'b0;
        check("fd_count", 32'(fd_cyc.size()), 32'd2);
        if (fd_cyc.size() >= 2) begin
            check("fd_first", 32'(fd_cyc[0]), 32'd16);
            check("fd_period", 32'(fd_cyc[1] - fd_cyc[0]), 32'd16);
        end

        wait_lit(1);
        digits = 16'h9876;
        run(32);

        wait_lit(3);
        dig_en = 4'b1011;
        run(32);
        dig_en = 4'b1111;

        wait_lit(1);
        en = 1'b0;
        run(1);
        check("en_dark", 32'(an_out), 32'hF);
        run(4);
        en = 1'b1;
        run(2);
        check("en_resume_an", 32'(an_out), 32'hB);
        run(10);

        wait_lit(3);
        rst_n = 1'b0;
        run(1);
        check("midrst_an", 32'(an_out), 32'hF);
        check("midrst_bcd", 32'(bcd_out), 32'h0);
        rst_n = 1'b1;
        run(1);
        check("restart_an", 32'(an_out), 32'hE);
        check("restart_bcd", 32'(bcd_out), 32'h6);
        run(20);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 16 == 0) digits = 16'($urandom);
            if ($urandom % 32 == 0) dig_en = 4'($urandom);
            if ($urandom % 40 == 0) en = ~en;
            rst_n = ($urandom % 300 != 0);
            run(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
